traffic_light_controller: RTL and testbench
===========================================

// Module: traffic_light_controller
// PURPOSE
//  Two-road (main/side) intersection sequencer. Advances only on single-cycle tick
//  strobes from the prescaler (typically 1 Hz). Main road rests green. Side road is
//  served only on side_req or a latched pedestrian request. Light outputs are
//  decoded from registered state: no combinational path from inputs to outputs.
// PARAMETERS
//  GREEN_MAIN_TICKS  10  minimum main green, ticks (>=1)
//  GREEN_SIDE_TICKS   6  side green duration, ticks (>=1)
//  YELLOW_TICKS       3  yellow duration, both roads (>=1)
//  ALL_RED_TICKS      1  all-red clearance duration (>=1)
//  CNT_W              8  tick counter width; every *_TICKS must be < 2**CNT_W
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  synchronous reset, active-low
//  tick        in   1  one-cycle advance strobe from prescaler
//  side_req    in   1  side-road vehicle sensor, level
//  ped_req     in   1  pedestrian button, pulse (any width), latched internally
//  night_mode  in   1  night flashing request (NIGHT_FLASH_EN only)
//  main_light  out  3  {red,yellow,green}, main road
//  side_light  out  3  {red,yellow,green}, side road
//  walk        out  1  pedestrian walk lamp
//  state_o     out  3  current state encoding (debug)
// BEHAVIOUR
//  States: MG=0 main green, MY=1 main yellow, AR_A=2 all red, SG=3 side green,
//   SY=4 side yellow, AR_B=5 all red, FL=6 flash. Codes 7 (and 6 without the macro)
//   go to AR_B on the next clk, cnt=0.
//  Reset (rst_n=0 at posedge): state=AR_B, cnt=0, ped_pend=0, walk=0,
//   main_light=3'b100, side_light=3'b100.
//  cnt is cleared on every state change. It advances only on cycles with tick=1.
//   On tick with cnt==DUR-1 the timed state is exited; otherwise cnt+1.
//   Tick-to-state-change latency is 1 clk.
//  MG: when cnt==GREEN_MAIN_TICKS-1 on tick, leave to MY if side_req|ped_pend.
//   Otherwise cnt holds saturated and the check repeats on every later tick.
//  MY (YELLOW_TICKS) -> AR_A (ALL_RED_TICKS) -> SG (GREEN_SIDE_TICKS) ->
//   SY (YELLOW_TICKS) -> AR_B (ALL_RED_TICKS) -> MG.
//  Lights: MG 001/100; MY 010/100; SG 100/001; SY 100/010; AR_A,AR_B 100/100.
//  ped_pend: set by ped_req=1 in any cycle. Cleared on the clk that enters SG.
//   If set and clear coincide, set wins and the request is served next cycle.
//  walk: registered on SG entry as ped_pend's value. Held through SG only.
//   Cleared on SG exit and when rst_n=0.
//  tick while rst_n=0 is ignored. tick with no timed expiry changes only cnt.
//  Mid-sequence reset restarts at AR_B. There is never a direct green->green path.
// CONFIGURATION
//  NIGHT_FLASH_EN defined: night_mode port exists.
//   At MG expiry, night_mode=1 has priority over requests: MG->MY->AR_A->FL.
//   In FL: main_light=3'b0y0, side_light=3'br00, walk=0. y and r are one shared
//   phase bit, set to 1 on FL entry and toggled on each tick.
//   On a tick in FL with night_mode=0 -> AR_B -> MG. ped_pend is kept through FL.
//  NIGHT_FLASH_EN undefined: no night_mode port. FL is unreachable and code 6 is
//   treated as illegal.
// TESTING
//  T1 reset: rst_n=0 for 2 clk -> state_o=5, lights 100/100, walk=0.
//   Release; after 1 tick -> MG (001/100).
//  T2 rest: defaults, tick every 4 clk, no requests, 50 ticks -> MG held,
//   side_light=100 throughout.
//  T3 side cycle: side_req=1 at tick 3 of MG -> MY exactly on the 10th MG tick;
//   dwell MY 3, AR 1, SG 6, SY 3, AR 1 ticks, then MG.
//  T4 ped: 1-clk ped_req in MG -> ped_pend=1. SG entered with walk=1 for 6 ticks,
//   then ped_pend=0. Pulse coincident with SG entry -> second side cycle follows.
//  T5 reset mid-SG (cnt=3) -> next clk AR_B, walk=0, cnt=0.
//  T6 (NIGHT_FLASH_EN) night_mode=1, side_req=1 -> FL; main alternates 010/000 per
//   tick. Drop night_mode -> AR_B, then MG, then the side cycle is served.

Source files
------------

// File: rtl/traffic_light_controller.sv
// Two-road intersection sequencer, advanced by single-cycle tick strobes.
// Optional night flashing mode is enabled with `define NIGHT_FLASH_EN.
`timescale 1ns/1ps

module traffic_light_controller #(
  parameter int unsigned GREEN_MAIN_TICKS = 10,
  parameter int unsigned GREEN_SIDE_TICKS = 6,
  parameter int unsigned YELLOW_TICKS     = 3,
  parameter int unsigned ALL_RED_TICKS    = 1,
  parameter int unsigned CNT_W            = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       side_req,
  input  logic       ped_req,
`ifdef NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    MG   = 3'd0,
    MY   = 3'd1,
    AR_A = 3'd2,
    SG   = 3'd3,
    SY   = 3'd4,
    AR_B = 3'd5,
    FL   = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] MainLast   = CNT_W'(GREEN_MAIN_TICKS - 1);
  localparam logic [CNT_W-1:0] SideLast   = CNT_W'(GREEN_SIDE_TICKS - 1);
  localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] AllRedLast = CNT_W'(ALL_RED_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cntInc;
  logic             pedPend_q, pedPend_d;
  logic             walk_q, walk_d;
`ifdef NIGHT_FLASH_EN
  logic             phase_q, phase_d;
  logic             nightSeq_q, nightSeq_d;
`endif

  assign cntInc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pedPend_d = pedPend_q | ped_req;
    walk_d    = walk_q;
`ifdef NIGHT_FLASH_EN
    phase_d    = phase_q;
    nightSeq_d = nightSeq_q;
`endif

    case (state_q)
      MG: begin
        if (tick) begin
          if (cnt_q == MainLast) begin
`ifdef NIGHT_FLASH_EN
            if (night_mode) begin
              state_d    = MY;
              nightSeq_d = 1'b1;
            end else if (side_req || pedPend_q) begin
              state_d = MY;
            end
`else
            if (side_req || pedPend_q) begin
              state_d = MY;
            end
`endif
          end else begin
            cnt_d = cntInc;
          end
        end
      end
      MY: begin
        if (tick) begin
          if (cnt_q == YellowLast) state_d = AR_A;
          else                     cnt_d   = cntInc;
        end
      end
      AR_A: begin
        if (tick) begin
          if (cnt_q == AllRedLast) begin
`ifdef NIGHT_FLASH_EN
            state_d = nightSeq_q ? FL : SG;
`else
            state_d = SG;
`endif
          end else begin
            cnt_d = cntInc;
          end
        end
      end
      SG: begin
        if (tick) begin
          if (cnt_q == SideLast) state_d = SY;
          else                   cnt_d   = cntInc;
        end
      end
      SY: begin
        if (tick) begin
          if (cnt_q == YellowLast) state_d = AR_B;
          else                     cnt_d   = cntInc;
        end
      end
      AR_B: begin
        if (tick) begin
          if (cnt_q == AllRedLast) state_d = MG;
          else                     cnt_d   = cntInc;
        end
      end
`ifdef NIGHT_FLASH_EN
      FL: begin
        if (tick) begin
          if (!night_mode) state_d = AR_B;
          else             phase_d = ~phase_q;
        end
      end
`endif
      default: state_d = AR_B;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // A request arriving on the same clock as SG entry survives for the next cycle.
    if (state_d == SG && state_q != SG) begin
      pedPend_d = ped_req;
      walk_d    = pedPend_q;
    end
    if (state_d != SG) walk_d = 1'b0;

`ifdef NIGHT_FLASH_EN
    if (state_d == FL && state_q != FL) begin
      phase_d    = 1'b1;
      nightSeq_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= AR_B;
      cnt_q     <= '0;
      pedPend_q <= 1'b0;
      walk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pedPend_q <= pedPend_d;
      walk_q    <= walk_d;
    end
  end

`ifdef NIGHT_FLASH_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q    <= 1'b0;
      nightSeq_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      nightSeq_q <= nightSeq_d;
    end
  end
`endif

  // Lights depend on registered state only.
  always_comb begin
    main_light = 3'b100;
    side_light = 3'b100;
    case (state_q)
      MG: main_light = 3'b001;
      MY: main_light = 3'b010;
      SG: side_light = 3'b001;
      SY: side_light = 3'b010;
`ifdef NIGHT_FLASH_EN
      FL: begin
        main_light = {1'b0, phase_q, 1'b0};
        side_light = {phase_q, 2'b00};
      end
`endif
      default: ;
    endcase
  end

  assign walk    = walk_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller; night tests need `define NIGHT_FLASH_EN.
`timescale 1ns/1ps

module tb_traffic_light_controller;

  localparam logic [2:0] S_MG = 3'd0, S_MY = 3'd1, S_ARA = 3'd2, S_SG = 3'd3,
                         S_SY = 3'd4, S_ARB = 3'd5, S_FL = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       side_req;
  logic       ped_req;
`ifdef NIGHT_FLASH_EN
  logic       night_mode;
`endif
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  traffic_light_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .side_req   (side_req),
    .ped_req    (ped_req),
`ifdef NIGHT_FLASH_EN
    .night_mode (night_mode),
`endif
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // One tick strobe followed by three idle clocks (tick every 4 clk).
  task automatic applyStimulus();
    tick = 1'b1;
    stepClk();
    tick = 1'b0;
    repeat (3) stepClk();
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (2) stepClk();
    rst_n = 1'b1;
  endtask

  task automatic checkLights(input string tag, input logic [2:0] st, input logic [2:0] m,
                             input logic [2:0] s, input logic w);
    checkOutput({tag, "_state"}, 8'(state_o), 8'(st));
    checkOutput({tag, "_main"}, 8'(main_light), 8'(m));
    checkOutput({tag, "_side"}, 8'(side_light), 8'(s));
    checkOutput({tag, "_walk"}, 8'(walk), 8'(w));
  endtask

  task automatic dwell(input string tag, input logic [2:0] st, input int n, input logic [2:0] nxt);
    for (int i = 1; i <= n; i++) begin
      applyStimulus();
      checkOutput(tag, 8'(state_o), (i < n) ? 8'(st) : 8'(nxt));
    end
  endtask

  // From MY, run the remainder of a side cycle back to MG with the given walk lamp in SG.
  task automatic sideCycle(input string tag, input logic w);
    checkLights({tag, "_my"}, S_MY, 3'b010, 3'b100, 1'b0);
    dwell({tag, "_my_dwell"}, S_MY, 3, S_ARA);
    checkLights({tag, "_ara"}, S_ARA, 3'b100, 3'b100, 1'b0);
    dwell({tag, "_ara_dwell"}, S_ARA, 1, S_SG);
    checkLights({tag, "_sg"}, S_SG, 3'b100, 3'b001, w);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus();
      if (i < 6) begin
        checkOutput({tag, "_sg_dwell"}, 8'(state_o), 8'(S_SG));
        checkOutput({tag, "_sg_walk"}, 8'(walk), 8'(w));
      end else begin
        checkOutput({tag, "_sg_exit"}, 8'(state_o), 8'(S_SY));
      end
    end
    checkLights({tag, "_sy"}, S_SY, 3'b100, 3'b010, 1'b0);
    dwell({tag, "_sy_dwell"}, S_SY, 3, S_ARB);
    checkLights({tag, "_arb"}, S_ARB, 3'b100, 3'b100, 1'b0);
    dwell({tag, "_arb_dwell"}, S_ARB, 1, S_MG);
    checkLights({tag, "_mg"}, S_MG, 3'b001, 3'b100, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    tick     = 1'b0;
    side_req = 1'b0;
    ped_req  = 1'b0;
`ifdef NIGHT_FLASH_EN
    night_mode = 1'b0;
`endif

    // T1: reset state, tick ignored during reset
    repeat (2) stepClk();
    checkLights("t1_reset", S_ARB, 3'b100, 3'b100, 1'b0);
    tick = 1'b1;
    stepClk();
    tick = 1'b0;
    checkOutput("t1_tick_in_reset", 8'(state_o), 8'(S_ARB));
    rst_n = 1'b1;
    repeat (3) stepClk();
    checkOutput("t1_no_tick_hold", 8'(state_o), 8'(S_ARB));
    applyStimulus();
    checkLights("t1_to_mg", S_MG, 3'b001, 3'b100, 1'b0);

    // T2: main green rests with no requests
    for (int i = 0; i < 50; i++) begin
      applyStimulus();
      checkOutput("t2_rest_state", 8'(state_o), 8'(S_MG));
      checkOutput("t2_rest_side", 8'(side_light), 8'b100);
    end
    side_req = 1'b1;
    applyStimulus();
    checkOutput("t2_saturated_exit", 8'(state_o), 8'(S_MY));
    side_req = 1'b0;
    sideCycle("t2c", 1'b0);

    // T3: side request at tick 3 of a fresh main green
    applyReset();
    applyStimulus();
    checkOutput("t3_mg", 8'(state_o), 8'(S_MG));
    applyStimulus();
    applyStimulus();
    side_req = 1'b1;
    for (int t = 3; t <= 10; t++) begin
      applyStimulus();
      checkOutput("t3_mg_count", 8'(state_o), (t < 10) ? 8'(S_MG) : 8'(S_MY));
    end
    side_req = 1'b0;
    sideCycle("t3", 1'b0);
    repeat (5) stepClk();
    checkOutput("t3_idle_no_tick", 8'(state_o), 8'(S_MG));

    // T4: pedestrian pulse in main green
    ped_req = 1'b1;
    stepClk();
    ped_req = 1'b0;
    dwell("t4_mg", S_MG, 10, S_MY);
    sideCycle("t4", 1'b1);
    dwell("t4_pend_cleared", S_MG, 10, S_MG);

    // T4b: pulse coincident with SG entry brings a second cycle
    side_req = 1'b1;
    applyStimulus();
    checkOutput("t4b_my", 8'(state_o), 8'(S_MY));
    side_req = 1'b0;
    dwell("t4b_my_dwell", S_MY, 3, S_ARA);
    tick    = 1'b1;
    ped_req = 1'b1;
    stepClk();
    tick    = 1'b0;
    ped_req = 1'b0;
    repeat (3) stepClk();
    checkOutput("t4b_sg", 8'(state_o), 8'(S_SG));
    dwell("t4b_sg_dwell", S_SG, 6, S_SY);
    dwell("t4b_sy_dwell", S_SY, 3, S_ARB);
    dwell("t4b_arb_dwell", S_ARB, 1, S_MG);
    dwell("t4b_second", S_MG, 10, S_MY);
    sideCycle("t4c", 1'b1);

    // T5: reset in the middle of side green
    side_req = 1'b1;
    dwell("t5_mg", S_MG, 10, S_MY);
    side_req = 1'b0;
    dwell("t5_my", S_MY, 3, S_ARA);
    dwell("t5_ara", S_ARA, 1, S_SG);
    repeat (3) applyStimulus();
    checkOutput("t5_sg_mid", 8'(state_o), 8'(S_SG));
    rst_n = 1'b0;
    stepClk();
    checkLights("t5_reset", S_ARB, 3'b100, 3'b100, 1'b0);
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("t5_restart_mg", 8'(state_o), 8'(S_MG));

`ifdef NIGHT_FLASH_EN
    // T6: night flashing has priority over the side request
    night_mode = 1'b1;
    side_req   = 1'b1;
    dwell("t6_mg", S_MG, 10, S_MY);
    dwell("t6_my", S_MY, 3, S_ARA);
    dwell("t6_ara", S_ARA, 1, S_FL);
    checkLights("t6_fl_on", S_FL, 3'b010, 3'b100, 1'b0);
    applyStimulus();
    checkLights("t6_fl_off", S_FL, 3'b000, 3'b000, 1'b0);
    applyStimulus();
    checkLights("t6_fl_on2", S_FL, 3'b010, 3'b100, 1'b0);
    night_mode = 1'b0;
    applyStimulus();
    checkOutput("t6_exit_arb", 8'(state_o), 8'(S_ARB));
    applyStimulus();
    checkOutput("t6_mg", 8'(state_o), 8'(S_MG));
    dwell("t6_served", S_MG, 10, S_MY);
    side_req = 1'b0;
    sideCycle("t6", 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
